simple_logic: RTL and testbench
===============================

// Module: simple_logic
// PURPOSE
//   Registered two-operand bitwise logic unit: AND, OR and XOR of inputs a and b.
//   Captures operands on enable and presents results one clock later with a valid strobe.
//   Counts operand changes for debug. Leaf block used as a glue/demo element.
// PARAMETERS
//   WIDTH    1   bit width of a, b, o1, o2, o3
//   CNT_W    16  width of chg_cnt
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst_n    in   1      asynchronous, active-low reset
//   en       in   1      capture enable for a/b
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B
//   o1       out  WIDTH  a & b (registered)
//   o2       out  WIDTH  a | b (registered)
//   o3       out  WIDTH  a ^ b (registered)
//   vld      out  1      high one cycle after each en-cycle
//   chg_cnt  out  CNT_W  number of captures whose {a,b} differed from previous capture
// BEHAVIOUR
//   - Reset: rst_n low forces o1=o2=o3=0, vld=0, chg_cnt=0 immediately.
//     The internal previous-operand register resets to 0 (a and b both 0).
//     Effect of rst_n is asynchronous; release is sampled on the next clk edge.
//   - Capture: on a rising clk edge with en=1, o1<=a&b, o2<=a|b, o3<=a^b, vld<=1.
//     Latency is 1 cycle from the en edge to the outputs.
//   - Hold: on a rising clk edge with en=0, o1/o2/o3 hold their values and vld<=0.
//   - Back-to-back en: a new result is produced every cycle; vld stays high.
//   - Change count: on a capture, if {a,b} differs from the last captured {a,b}:
//     - chg_cnt increments;
//     - saturates at 2^CNT_W-1 (no wrap).
//     The first capture after reset is compared against 0.
//   - All operations are purely bitwise per bit index; no carries.
//     All WIDTH bits are independent.
//   - X on a/b while en=0 must not disturb any output or counter.
//   - Reset asserted mid-stream clears outputs in the same cycle.
//     The first post-reset capture behaves exactly like the first capture after power-up.
// CONFIGURATION
//   SIMPLE_LOGIC_PARITY_EN defined:
//     - extra output port par (1 bit) = reduction XOR of the o3 value being loaded.
//     - par has the same 1-cycle latency and hold behaviour as o3; reset value 0.
//   SIMPLE_LOGIC_PARITY_EN undefined:
//     - port par does not exist; no parity logic is generated.
// TESTING
//   (WIDTH=1; each step drives en=1 for one cycle, then the outputs are checked.)
//   - Reset: rst_n=0 with a=b=1 -> o1=o2=o3=0, vld=0, chg_cnt=0, asynchronously.
//   - a=0,b=0 -> o1/o2/o3=0/0/0, vld=1, chg_cnt=0.
//   - Sweep a=0,b=1 then a=1,b=0 then a=1,b=1:
//     - a=0,b=1 -> o1/o2/o3 = 0/1/1;
//     - a=1,b=0 -> o1/o2/o3 = 0/1/1;
//     - a=1,b=1 -> o1/o2/o3 = 1/1/0;
//     - chg_cnt = 3 at the end of the sweep.
//   - Hold: en=0 with a/b toggling for 5 cycles:
//     - o1/o2/o3 frozen at 1/1/0;
//     - vld=0;
//     - chg_cnt unchanged.
//   - Repeat: same {a,b} captured twice -> chg_cnt does not increment.
//   - Saturation: CNT_W=2, more than 4 distinct captures -> chg_cnt stays at 3.
//   - With the macro, WIDTH=4, a=4'b1010, b=4'b0110 -> o3=4'b1100, par=0.

Source files
------------

// File: rtl/simple_logic_if.sv
// Operand/result bundle for simple_logic; the master drives operands, the slave returns results.
// Carries the par signal only when SIMPLE_LOGIC_PARITY_EN is defined.
interface simple_logic_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);

  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic             vld;
  logic [CNT_W-1:0] chg_cnt;

`ifdef SIMPLE_LOGIC_PARITY_EN
  logic             par;

  modport master (
    output en, a, b,
    input  o1, o2, o3, vld, chg_cnt, par
  );

  modport slave (
    input  en, a, b,
    output o1, o2, o3, vld, chg_cnt, par
  );
`else
  modport master (
    output en, a, b,
    input  o1, o2, o3, vld, chg_cnt
  );

  modport slave (
    input  en, a, b,
    output o1, o2, o3, vld, chg_cnt
  );
`endif

endinterface

// File: rtl/simple_logic.sv
// Registered bitwise AND/OR/XOR unit with a valid strobe and a saturating operand-change counter.
// Optional registered parity of the XOR result is enabled by defining SIMPLE_LOGIC_PARITY_EN.
module simple_logic #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  simple_logic_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   o1_q, o1_d;
  logic [WIDTH-1:0]   o2_q, o2_d;
  logic [WIDTH-1:0]   o3_q, o3_d;
  logic               vld_q, vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prev_q, prev_d;
  logic [2*WIDTH-1:0] cur;

  assign cur = {bus.a, bus.b};

  // Operands are only looked at when en is high, so X on a/b while idle cannot leak in.
  always_comb begin
    o1_d   = o1_q;
    o2_d   = o2_q;
    o3_d   = o3_q;
    vld_d  = 1'b0;
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (bus.en) begin
      o1_d   = bus.a & bus.b;
      o2_d   = bus.a | bus.b;
      o3_d   = bus.a ^ bus.b;
      vld_d  = 1'b1;
      prev_d = cur;
      if ((cur != prev_q) && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o1_q   <= '0;
      o2_q   <= '0;
      o3_q   <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      o1_q   <= o1_d;
      o2_q   <= o2_d;
      o3_q   <= o3_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

  assign bus.o1      = o1_q;
  assign bus.o2      = o2_q;
  assign bus.o3      = o3_q;
  assign bus.vld     = vld_q;
  assign bus.chg_cnt = cnt_q;

`ifdef SIMPLE_LOGIC_PARITY_EN
  logic par_q, par_d;

  // Parity tracks o3 exactly: same load condition, same hold, same reset.
  always_comb begin
    par_d = par_q;
    if (bus.en) begin
      par_d = ^(bus.a ^ bus.b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.par = par_q;
`endif

endmodule

// File: tb/tb_simple_logic.sv
// Bench for simple_logic: a 1-bit/16-bit counter DUT and a 1-bit/2-bit counter DUT share stimulus,
// plus a 4-bit DUT for the wide and parity cases.
module tb_simple_logic;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  simple_logic_if #(.WIDTH(1), .CNT_W(16)) bus0 ();
  simple_logic_if #(.WIDTH(1), .CNT_W(2))  bus1 ();
  simple_logic_if #(.WIDTH(4), .CNT_W(16)) bus2 ();

  assign bus1.en = bus0.en;
  assign bus1.a  = bus0.a;
  assign bus1.b  = bus0.b;

  simple_logic #(.WIDTH(1), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  simple_logic #(.WIDTH(1), .CNT_W(2))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  simple_logic #(.WIDTH(4), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: last result, last captured pair and change counts for each DUT.
  logic [0:0] mO1, mO2, mO3;
  logic       mVld;
  logic [1:0] mPrev;
  int         mCntA;
  int         mCntB;
  logic [3:0] wO1, wO2, wO3;
  logic       wVld, wPar;
  logic [7:0] wPrev;
  int         wCnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic av, input logic bv);
    bus0.en = e;
    bus0.a  = av;
    bus0.b  = bv;
    @(negedge clk);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mO1 = 0; mO2 = 0; mO3 = 0; mVld = 0; mPrev = 0; mCntA = 0; mCntB = 0;
      wO1 = 0; wO2 = 0; wO3 = 0; wVld = 0; wPar = 0; wPrev = 0; wCnt = 0;
    end else begin
      mVld = bus0.en;
      if (bus0.en) begin
        mO1 = bus0.a & bus0.b;
        mO2 = bus0.a | bus0.b;
        mO3 = bus0.a ^ bus0.b;
        if ({bus0.a, bus0.b} != mPrev) begin
          mCntA = (mCntA < 65535) ? mCntA + 1 : mCntA;
          mCntB = (mCntB < 3) ? mCntB + 1 : mCntB;
        end
        mPrev = {bus0.a, bus0.b};
      end
      wVld = bus2.en;
      if (bus2.en) begin
        wO1  = bus2.a & bus2.b;
        wO2  = bus2.a | bus2.b;
        wO3  = bus2.a ^ bus2.b;
        wPar = ^(bus2.a ^ bus2.b);
        if ({bus2.a, bus2.b} != wPrev) wCnt = (wCnt < 65535) ? wCnt + 1 : wCnt;
        wPrev = {bus2.a, bus2.b};
      end
    end
  end

  // Every falling edge all three DUTs are held against the reference.
  always @(negedge clk) begin
    checkOutput("m0.o1",  32'(bus0.o1),      32'(mO1));
    checkOutput("m0.o2",  32'(bus0.o2),      32'(mO2));
    checkOutput("m0.o3",  32'(bus0.o3),      32'(mO3));
    checkOutput("m0.vld", 32'(bus0.vld),     32'(mVld));
    checkOutput("m0.cnt", 32'(bus0.chg_cnt), 32'(mCntA));
    checkOutput("m1.o3",  32'(bus1.o3),      32'(mO3));
    checkOutput("m1.vld", 32'(bus1.vld),     32'(mVld));
    checkOutput("m1.cnt", 32'(bus1.chg_cnt), 32'(mCntB));
    checkOutput("m2.o1",  32'(bus2.o1),      32'(wO1));
    checkOutput("m2.o2",  32'(bus2.o2),      32'(wO2));
    checkOutput("m2.o3",  32'(bus2.o3),      32'(wO3));
    checkOutput("m2.vld", 32'(bus2.vld),     32'(wVld));
    checkOutput("m2.cnt", 32'(bus2.chg_cnt), 32'(wCnt));
`ifdef SIMPLE_LOGIC_PARITY_EN
    checkOutput("m2.par", 32'(bus2.par),     32'(wPar));
`endif
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b1;
    bus0.en = 1'b1;
    bus0.a  = 1'b1;
    bus0.b  = 1'b1;
    bus2.en = 1'b0;
    bus2.a  = 4'h0;
    bus2.b  = 4'h0;

    // Reset asserted before any clock edge must clear everything on its own.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst.o1",  32'(bus0.o1),      32'd0);
    checkOutput("rst.o2",  32'(bus0.o2),      32'd0);
    checkOutput("rst.o3",  32'(bus0.o3),      32'd0);
    checkOutput("rst.vld", 32'(bus0.vld),     32'd0);
    checkOutput("rst.cnt", 32'(bus0.chg_cnt), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rstHeld.vld", 32'(bus0.vld), 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cap00.o", 32'({bus0.o1, bus0.o2, bus0.o3}), 32'b000);
    checkOutput("cap00.vld", 32'(bus0.vld), 32'd1);
    checkOutput("cap00.cnt", 32'(bus0.chg_cnt), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("cap01.o", 32'({bus0.o1, bus0.o2, bus0.o3}), 32'b011);
    checkOutput("cap01.vld", 32'(bus0.vld), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("cap10.o", 32'({bus0.o1, bus0.o2, bus0.o3}), 32'b011);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("cap11.o", 32'({bus0.o1, bus0.o2, bus0.o3}), 32'b110);
    checkOutput("sweep.cnt", 32'(bus0.chg_cnt), 32'd3);
    checkOutput("sweep.cnt2", 32'(bus1.chg_cnt), 32'd3);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, (i == 2) ? 1'bx : 1'(i), (i == 3) ? 1'bx : 1'(~i));
      checkOutput("hold.o", 32'({bus0.o1, bus0.o2, bus0.o3}), 32'b110);
      checkOutput("hold.vld", 32'(bus0.vld), 32'd0);
      checkOutput("hold.cnt", 32'(bus0.chg_cnt), 32'd3);
    end

    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("repeat.cnt", 32'(bus0.chg_cnt), 32'd3);
    checkOutput("b2b.vld", 32'(bus0.vld), 32'd1);

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("more.cnt", 32'(bus0.chg_cnt), 32'd6);
    checkOutput("sat.cnt2", 32'(bus1.chg_cnt), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);

    bus2.en = 1'b1;
    bus2.a  = 4'b1010;
    bus2.b  = 4'b0110;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("w.o1", 32'(bus2.o1), 32'h2);
    checkOutput("w.o2", 32'(bus2.o2), 32'hE);
    checkOutput("w.o3", 32'(bus2.o3), 32'hC);
`ifdef SIMPLE_LOGIC_PARITY_EN
    checkOutput("w.par", 32'(bus2.par), 32'd0);
`endif
    bus2.a = 4'b1011;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("w2.o3", 32'(bus2.o3), 32'hD);
    checkOutput("w2.cnt", 32'(bus2.chg_cnt), 32'd2);
`ifdef SIMPLE_LOGIC_PARITY_EN
    checkOutput("w2.par", 32'(bus2.par), 32'd1);
`endif
    bus2.en = 1'b0;
    bus2.a  = 4'hx;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("wHold.o3", 32'(bus2.o3), 32'hD);

    // Mid-stream reset clears within the cycle; the next capture is a fresh first capture.
    applyStimulus(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst.o", 32'({bus0.o1, bus0.o2, bus0.o3}), 32'b000);
    checkOutput("midRst.cnt", 32'(bus0.chg_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("postRst.cnt", 32'(bus0.chg_cnt), 32'd0);
    checkOutput("postRst.vld", 32'(bus0.vld), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("postRst2.cnt", 32'(bus0.chg_cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
